// File: rtl/mem_access_fsm_pkg.sv
// Shared encodings for the load/store memory access sequencer and its helpers.
package mem_access_fsm_pkg;

    localparam logic [1:0]  SZ_B     = 2'b00;
    localparam logic [1:0]  SZ_H     = 2'b01;
    localparam logic [1:0]  SZ_W     = 2'b10;
    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ST_BEAT = 3'd1,
        RD_ADDR = 3'd2,
        RD_WAIT = 3'd3,
        RD_CAP  = 3'd4,
        FIN     = 3'd5
    } state_e;

    // Size code 11 is an alias for a word access.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_fsm_load_extend.sv
// Keeps the low 1/2/4 bytes of a little-endian word and sign- or zero-extends them.
module load_extend
    import mem_access_fsm_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    always_comb begin
        data_o = data_i;
        case (size_i)
            SZ_B:    data_o = {{24{~unsigned_i & data_i[7]}},  data_i[7:0]};
            SZ_H:    data_o = {{16{~unsigned_i & data_i[15]}}, data_i[15:0]};
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/mem_access_fsm.sv
// Multi-beat load/store sequencer: splits a byte/half/word access into bus-width
// beats, waits a fixed read latency per load beat and extends the load result.
module mem_access_fsm
    import mem_access_fsm_pkg::*;
#(
    parameter int BUS_BYTES = 1,
    parameter int RD_LAT    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_i,
    input  logic                   we_i,
    input  logic [1:0]             size_i,
    input  logic                   unsigned_i,
    input  logic [31:0]            addr_i,
    input  logic [31:0]            wdata_i,
    input  logic                   flush_i,
    input  logic [8*BUS_BYTES-1:0] mem_rdata_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [31:0]            rdata_o,
    output logic [31:0]            mem_addr_o,
    output logic                   mem_we_o,
    output logic [8*BUS_BYTES-1:0] mem_wdata_o
);

    localparam int BB_SHIFT = $clog2(BUS_BYTES);

    state_e      state_q, state_d;
    logic [2:0]  beat_q, beat_d;
    logic [2:0]  lat_q, lat_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] cap_q, cap_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] ext_data;
    logic [2:0]  nbytes;
    logic [2:0]  last_beat;
    logic        in_beat;
    logic [3:0]  lane_idx [BUS_BYTES];

    assign nbytes    = size_bytes(size_q);
    assign last_beat = ((nbytes + 3'(BUS_BYTES - 1)) >> BB_SHIFT) - 3'd1;

    // Byte position within the access that bus lane j carries in the current beat.
    for (genvar j = 0; j < BUS_BYTES; j++) begin : g_lane
        assign lane_idx[j] = 4'({1'b0, beat_q} << BB_SHIFT) + 4'(j);
    end

    assign in_beat    = (state_q == ST_BEAT) || (state_q == RD_ADDR) ||
                        (state_q == RD_WAIT) || (state_q == RD_CAP);
    assign mem_addr_o = in_beat ? addr_q + (32'(beat_q) << BB_SHIFT) : ZeroWord;
    assign mem_we_o   = (state_q == ST_BEAT);
    assign busy_o     = (state_q != IDLE);
    assign done_o     = (state_q == FIN);
    assign rdata_o    = rdata_q;

    always_comb begin
        mem_wdata_o = '0;
        if (state_q == ST_BEAT) begin
            for (int j = 0; j < BUS_BYTES; j++) begin
                if (lane_idx[j] < {1'b0, nbytes}) begin
                    mem_wdata_o[8*j +: 8] = wdata_q[{lane_idx[j][1:0], 3'b000} +: 8];
                end
            end
        end
    end

    // Lanes that land past byte 3 of the word have nowhere to go and are dropped.
    always_comb begin
        cap_d = cap_q;
        if (state_q == RD_CAP && !flush_i) begin
            for (int j = 0; j < BUS_BYTES; j++) begin
                if (lane_idx[j] < 4'd4) begin
                    cap_d[{lane_idx[j][1:0], 3'b000} +: 8] = mem_rdata_i[8*j +: 8];
                end
            end
        end
    end

    load_extend u_load_extend (
        .data_i     (cap_d),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .data_o     (ext_data)
    );

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        lat_d   = lat_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        rdata_d = rdata_q;
        if (flush_i && state_q != IDLE) begin
            state_d = IDLE;
            beat_d  = 3'd0;
            lat_d   = 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_i && !flush_i) begin
                        addr_d  = addr_i;
                        wdata_d = wdata_i;
                        size_d  = size_i;
                        uns_d   = unsigned_i;
                        beat_d  = 3'd0;
                        lat_d   = 3'd0;
                        state_d = we_i ? ST_BEAT : RD_ADDR;
                    end
                end
                ST_BEAT: begin
                    if (beat_q == last_beat) state_d = FIN;
                    else                     beat_d  = beat_q + 3'd1;
                end
                RD_ADDR: begin
                    if (RD_LAT == 1) begin
                        state_d = RD_CAP;
                    end else begin
                        state_d = RD_WAIT;
                        lat_d   = 3'd1;
                    end
                end
                RD_WAIT: begin
                    if (lat_q == 3'(RD_LAT - 1)) state_d = RD_CAP;
                    else                         lat_d   = lat_q + 3'd1;
                end
                RD_CAP: begin
                    lat_d = 3'd0;
                    if (beat_q == last_beat) begin
                        state_d = FIN;
                        rdata_d = ext_data;
                    end else begin
                        beat_d  = beat_q + 3'd1;
                        state_d = RD_ADDR;
                    end
                end
                FIN: begin
                    state_d = IDLE;
                    beat_d  = 3'd0;
                    lat_d   = 3'd0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= 3'd0;
            lat_q   <= 3'd0;
            addr_q  <= ZeroWord;
            wdata_q <= ZeroWord;
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
            cap_q   <= ZeroWord;
            rdata_q <= ZeroWord;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            lat_q   <= lat_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            cap_q   <= cap_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_access_fsm.sv
// Bench for mem_access_fsm in two bus configurations (1 byte / RD_LAT 2 and 4 bytes / RD_LAT 1),
// with a byte-addressed memory model, done/beat scoreboards and randomized accesses.
module tb_mem_access_fsm;
    import mem_access_fsm_pkg::*;

    typedef struct {
        int          u;
        int          cyc;
        logic [31:0] rd;
    } done_t;

    typedef struct {
        int          u;
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    logic             clk = 1'b0;
    logic [1:0]       rst, req, we, uns, flush;
    logic [1:0][1:0]  size;
    logic [1:0][31:0] addr, wdata, mem_rdata;
    logic [1:0]       busy, done, mem_we;
    logic [1:0][31:0] rdata, mem_addr, mem_wdata;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    done_t       done_q [$];
    beat_t       beat_q [$];
    done_t       mon_d;
    beat_t       mon_b;
    logic [7:0]  mem_model [logic [32:0]];
    logic [31:0] last_rd [2];
    logic [31:0] pipe_a [2][8];
    logic        pipe_v [2][8];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int BB  = (g == 0) ? 1 : 4;
        localparam int LAT = (g == 0) ? 2 : 1;
        logic [8*BB-1:0] wd_w;
        mem_access_fsm #(.BUS_BYTES(BB), .RD_LAT(LAT)) dut (
            .clk         (clk),
            .rst         (rst[g]),
            .req_i       (req[g]),
            .we_i        (we[g]),
            .size_i      (size[g]),
            .unsigned_i  (uns[g]),
            .addr_i      (addr[g]),
            .wdata_i     (wdata[g]),
            .flush_i     (flush[g]),
            .mem_rdata_i (mem_rdata[g][8*BB-1:0]),
            .busy_o      (busy[g]),
            .done_o      (done[g]),
            .rdata_o     (rdata[g]),
            .mem_addr_o  (mem_addr[g]),
            .mem_we_o    (mem_we[g]),
            .mem_wdata_o (wd_w)
        );
        assign mem_wdata[g] = 32'(wd_w);
    end

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int bb_of(input int u);
        return (u == 0) ? 1 : 4;
    endfunction

    function automatic int lat_of(input int u);
        return (u == 0) ? 2 : 1;
    endfunction

    function automatic logic [7:0] mem_rd(input int u, input logic [31:0] a);
        logic [32:0] k;
        k = {u[0], a};
        if (mem_model.exists(k)) return mem_model[k];
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
    endfunction

    function automatic logic [31:0] mem_word(input int u, input logic [31:0] a);
        return {mem_rd(u, a + 32'd3), mem_rd(u, a + 32'd2), mem_rd(u, a + 32'd1), mem_rd(u, a)};
    endfunction

    function automatic logic [7:0] wd_byte(input logic [31:0] wd, input int i);
        return 8'(wd >> (8 * i));
    endfunction

    function automatic int size_n(input logic [1:0] sz);
        return (sz == SZ_B) ? 1 : (sz == SZ_H) ? 2 : 4;
    endfunction

    // Reference load: gather N bytes from the memory model, then extend from bit 8N-1.
    function automatic logic [31:0] ref_load(input int u, input logic [31:0] a,
                                             input logic [1:0] sz, input logic un);
        int          n;
        logic [31:0] v;
        n = size_n(sz);
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(mem_rd(u, a + 32'(i))) << (8 * i));
        if (!un && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    // Memory responder: data for an address seen RD_LAT cycles ago, garbage otherwise.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            for (int i = 1; i < 8; i++) begin
                pipe_a[u][i] <= pipe_a[u][i-1];
                pipe_v[u][i] <= pipe_v[u][i-1];
            end
            pipe_a[u][0] <= mem_addr[u];
            pipe_v[u][0] <= busy[u] && !done[u] && !mem_we[u];
            if (pipe_v[u][lat_of(u)-1] === 1'b1) mem_rdata[u] <= mem_word(u, pipe_a[u][lat_of(u)-1]);
            else                                 mem_rdata[u] <= $urandom;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    // Monitor: pops the scoreboards whenever a DUT presents a completion or a write beat.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (done[u] === 1'b1) begin
                if (done_q.size() == 0) begin
                    checkOutput("unexpected_done", 32'(done[u]), 32'd0);
                end else begin
                    mon_d = done_q.pop_front();
                    checkOutput("done_unit",  32'(u), 32'(mon_d.u));
                    checkOutput("done_cycle", 32'(cyc), 32'(mon_d.cyc));
                    checkOutput("done_rdata", rdata[u], mon_d.rd);
                    checkOutput("done_busy",  32'(busy[u]), 32'd1);
                end
            end
            if (mem_we[u] === 1'b1) begin
                if (beat_q.size() == 0) begin
                    checkOutput("unexpected_we", 32'(mem_we[u]), 32'd0);
                end else begin
                    mon_b = beat_q.pop_front();
                    checkOutput("beat_unit",  32'(u), 32'(mon_b.u));
                    checkOutput("beat_cycle", 32'(cyc), 32'(mon_b.cyc));
                    checkOutput("beat_addr",  mem_addr[u], mon_b.addr);
                    checkOutput("beat_wdata", mem_wdata[u], mon_b.data);
                end
            end
            if (busy[u] !== 1'b1 || done[u] === 1'b1) begin
                checkOutput("idle_mem_addr",  mem_addr[u], 32'd0);
                checkOutput("idle_mem_we",    32'(mem_we[u]), 32'd0);
                checkOutput("idle_mem_wdata", mem_wdata[u], 32'd0);
            end
        end
    end

    task automatic waitIdle(input int u);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (busy[u] === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) checkOutput("idle_timeout", 32'(busy[u]), 32'd0);
    endtask

    task automatic applyStimulus(input int u, input logic w, input logic [1:0] sz, input logic un,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic hold, input logic track, output int t);
        int          n, b, bb, lat;
        logic [31:0] d;
        done_t       de;
        beat_t       be;
        bit          seen;
        waitIdle(u);
        bb  = bb_of(u);
        lat = lat_of(u);
        n   = size_n(sz);
        b   = (n + bb - 1) / bb;
        req[u] = 1'b1; we[u] = w; size[u] = sz; uns[u] = un; addr[u] = a; wdata[u] = wd;
        t = cyc;
        if (w) begin
            for (int k = 0; k < b; k++) begin
                d = 32'd0;
                for (int j = 0; j < bb; j++)
                    if (k * bb + j < n) d = d | (32'(wd_byte(wd, k * bb + j)) << (8 * j));
                be.u = u; be.cyc = t + 1 + k; be.addr = a + 32'(k * bb); be.data = d;
                beat_q.push_back(be);
            end
            for (int i = 0; i < n; i++) mem_model[{u[0], a + 32'(i)}] = wd_byte(wd, i);
            if (track) begin
                de.u = u; de.cyc = t + 1 + b; de.rd = last_rd[u];
                done_q.push_back(de);
            end
        end else if (track) begin
            d = ref_load(u, a, sz, un);
            last_rd[u] = d;
            de.u = u; de.cyc = t + 1 + b * (lat + 1); de.rd = d;
            done_q.push_back(de);
        end
        @(posedge clk);
        #1;
        checkOutput("busy_after_accept", 32'(busy[u]), 32'd1);
        we[u] = 1'($urandom); size[u] = 2'($urandom); uns[u] = 1'($urandom);
        addr[u] = $urandom; wdata[u] = $urandom;
        req[u] = hold;
        if (hold) begin
            seen = 1'b0;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                if (done[u] === 1'b1) begin
                    seen = 1'b1;
                    break;
                end
            end
            req[u] = 1'b0;
            if (!seen) checkOutput("done_timeout", 32'(done[u]), 32'd1);
        end
    endtask

    task automatic checkResetState(input int u, input string tag);
        checkOutput({tag, "_busy"},      32'(busy[u]), 32'd0);
        checkOutput({tag, "_done"},      32'(done[u]), 32'd0);
        checkOutput({tag, "_rdata"},     rdata[u], 32'd0);
        checkOutput({tag, "_mem_addr"},  mem_addr[u], 32'd0);
        checkOutput({tag, "_mem_we"},    32'(mem_we[u]), 32'd0);
        checkOutput({tag, "_mem_wdata"}, mem_wdata[u], 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          t;
        logic [31:0] a;
        rst = 2'b11; req = '0; flush = '0; we = '0; uns = '0;
        size = '0; addr = '0; wdata = '0;
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        repeat (3) @(negedge clk);
        checkResetState(0, "reset0");
        checkResetState(1, "reset1");
        rst = 2'b00;

        mem_model[{1'b0, 32'h100}] = 8'h11;
        mem_model[{1'b0, 32'h101}] = 8'h22;
        mem_model[{1'b0, 32'h102}] = 8'h33;
        mem_model[{1'b0, 32'h103}] = 8'h44;
        mem_model[{1'b0, 32'h80}]  = 8'h80;
        mem_model[{1'b1, 32'h102}] = 8'h01;
        mem_model[{1'b1, 32'h103}] = 8'h80;
        mem_model[{1'b1, 32'h104}] = 8'hBB;
        mem_model[{1'b1, 32'h105}] = 8'hAA;

        applyStimulus(0, 1'b0, SZ_W, 1'b0, 32'h100, 32'd0, 1'b0, 1'b1, t);
        waitIdle(0);
        checkOutput("lw_0x100", rdata[0], 32'h4433_2211);

        applyStimulus(0, 1'b0, SZ_B, 1'b0, 32'h80, 32'd0, 1'b0, 1'b1, t);
        waitIdle(0);
        checkOutput("lb_0x80", rdata[0], 32'hFFFF_FF80);
        applyStimulus(0, 1'b0, SZ_B, 1'b1, 32'h80, 32'd0, 1'b0, 1'b1, t);
        waitIdle(0);
        checkOutput("lbu_0x80", rdata[0], 32'h0000_0080);

        applyStimulus(0, 1'b1, SZ_W, 1'b0, 32'h200, 32'hDEAD_BEEF, 1'b0, 1'b1, t);
        waitIdle(0);
        checkOutput("sw_keeps_rdata", rdata[0], 32'h0000_0080);
        applyStimulus(0, 1'b0, SZ_W, 1'b0, 32'h200, 32'd0, 1'b0, 1'b1, t);
        waitIdle(0);
        checkOutput("lw_after_sw", rdata[0], 32'hDEAD_BEEF);
        applyStimulus(0, 1'b0, SZ_H, 1'b0, 32'h100, 32'd0, 1'b0, 1'b1, t);
        waitIdle(0);
        checkOutput("lh_0x100", rdata[0], 32'h0000_2211);

        // Flush an untracked LW in its fourth cycle.
        applyStimulus(0, 1'b0, SZ_W, 1'b0, 32'h300, 32'd0, 1'b0, 1'b0, t);
        @(negedge clk);
        while (cyc != t + 3) @(negedge clk);
        flush[0] = 1'b1;
        @(posedge clk);
        #1;
        flush[0] = 1'b0;
        @(negedge clk);
        checkOutput("flush_busy",  32'(busy[0]), 32'd0);
        checkOutput("flush_done",  32'(done[0]), 32'd0);
        checkOutput("flush_rdata", rdata[0], 32'h0000_2211);
        repeat (20) @(negedge clk);

        // Reset in the middle of a store while req_i is held high.
        applyStimulus(0, 1'b1, SZ_W, 1'b0, 32'h240, 32'h1234_5678, 1'b0, 1'b0, t);
        req[0] = 1'b1;
        while (cyc != t + 2) @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        checkResetState(0, "midrst");
        rst[0] = 1'b0;
        req[0] = 1'b0;
        beat_q.delete();
        last_rd[0] = 32'd0;
        applyStimulus(0, 1'b0, SZ_B, 1'b1, 32'h101, 32'd0, 1'b0, 1'b1, t);
        waitIdle(0);
        checkOutput("lbu_after_rst", rdata[0], 32'h0000_0022);

        applyStimulus(1, 1'b0, SZ_H, 1'b0, 32'h102, 32'd0, 1'b0, 1'b1, t);
        waitIdle(1);
        checkOutput("lh_bus4_0x102", rdata[1], 32'hFFFF_8001);
        applyStimulus(1, 1'b1, SZ_W, 1'b0, 32'hFFFF_FFFE, 32'hCAFE_F00D, 1'b0, 1'b1, t);
        applyStimulus(1, 1'b0, SZ_W, 1'b0, 32'hFFFF_FFFE, 32'd0, 1'b0, 1'b1, t);
        waitIdle(1);
        checkOutput("lw_wrap_bus4", rdata[1], 32'hCAFE_F00D);

        for (int u = 0; u < 2; u++) begin
            for (int n = 0; n < ((u == 0) ? 150 : 100); n++) begin
                case ($urandom_range(0, 3))
                    0:       a = $urandom;
                    1:       a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
                    default: a = 32'($urandom_range(0, 63));
                endcase
                applyStimulus(u, 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom,
                              1'($urandom), 1'b1, t);
            end
            waitIdle(u);
        end

        repeat (10) @(negedge clk);
        checkOutput("done_queue_empty", 32'(done_q.size()), 32'd0);
        checkOutput("beat_queue_empty", 32'(beat_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
